// File: rtl/psg_write_sequencer.sv
// Purpose: queues internal-master PSG register writes and replays each as select/latch/write/restore phases on the TurboSound bus.
// Latency: a sequence starts the clock after the FIFO goes non-empty with the CPU idle; 4*(HOLD+1) owned clocks per entry (2*(HOLD+1) when a select is skipped).
// Backpressure: push_ready drops when the FIFO is full; CPU PSG cycles are stalled through cpu_wait while a sequence is running.
// Optional feature: define PSGSEQ_SKIP_SELECT_EN to skip the select and restore phases when the entry targets the chip already selected.
module psg_write_sequencer #(
    parameter int DEPTH = 16,
    parameter int HOLD  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic                     push_chip,
    input  logic [3:0]               push_reg,
    input  logic [7:0]               push_data,
    input  logic                     cpu_busy,
    input  logic                     cur_sel,
    output logic                     own,
    output logic                     bus_bdir,
    output logic                     bus_bc1,
    output logic [7:0]               bus_d,
    output logic                     cpu_wait,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
    localparam logic [AW:0]   FULL_C = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_ADDR,
        S_DATA,
        S_RST
    } state_t;

    // FIFO storage and pointers; entry layout is {chip, reg, data}
    logic [12:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [12:0]   head;
    logic          push_fire;
    logic          pop_fire;

    // Sequencer state and holding registers for the entry being replayed
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          chip_q, chip_d;
    logic [3:0]    reg_q, reg_d;
    logic [7:0]    data_q, data_d;
    logic          saved_sel_q, saved_sel_d;
    logic          skip_q, skip_d;
    logic          skip_start;

    // Registered bus outputs
    logic          own_q, own_d;
    logic          bdir_q, bdir_d;
    logic          bc1_q, bc1_d;
    logic [7:0]    dout_q, dout_d;
    logic          strobe;

    assign head       = mem[rd_ptr_q];
    assign push_ready = (count_q != FULL_C);
    assign push_fire  = push_valid && push_ready;
    assign level      = count_q;
    assign own        = own_q;
    assign bus_bdir   = bdir_q;
    assign bus_bc1    = bc1_q;
    assign bus_d      = dout_q;
    assign cpu_wait   = cpu_busy && (state_q != S_IDLE);

`ifdef PSGSEQ_SKIP_SELECT_EN
    // Entry already targets the selected chip: no need to reselect or restore
    assign skip_start = (head[12] == cur_sel);
`else
    assign skip_start = 1'b0;
`endif

    // FIFO pointer and occupancy update; simultaneous push and pop leave the count alone
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_fire);
        rd_ptr_d = rd_ptr_q + AW'(pop_fire);
        count_d  = count_q;
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Phase sequencing: each phase is HOLD strobe clocks followed by one gap clock
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chip_d      = chip_q;
        reg_d       = reg_q;
        data_d      = data_q;
        saved_sel_d = saved_sel_q;
        skip_d      = skip_q;
        pop_fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // CPU has priority while the bus is idle
                if ((count_q != '0) && !cpu_busy) begin
                    pop_fire    = 1'b1;
                    chip_d      = head[12];
                    reg_d       = head[11:8];
                    data_d      = head[7:0];
                    saved_sel_d = cur_sel;
                    skip_d      = skip_start;
                    cnt_d       = '0;
                    state_d     = skip_start ? S_ADDR : S_SEL;
                end
            end
            default: begin
                if (cnt_q == HOLD_C) begin
                    cnt_d = '0;
                    case (state_q)
                        S_SEL:   state_d = S_ADDR;
                        S_ADDR:  state_d = S_DATA;
                        S_DATA:  state_d = skip_q ? S_IDLE : S_RST;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Bus outputs decoded from the next state so they can be registered
    always_comb begin
        own_d  = (state_d != S_IDLE);
        strobe = own_d && (cnt_d != HOLD_C);
        bdir_d = strobe;
        bc1_d  = strobe && (state_d != S_DATA);
        case (state_d)
            S_SEL:   dout_d = {7'h7F, ~chip_d};
            S_ADDR:  dout_d = {4'h0, reg_d};
            S_DATA:  dout_d = data_d;
            S_RST:   dout_d = {7'h7F, ~saved_sel_d};
            default: dout_d = 8'h00;
        endcase
    end

    // FIFO data array; contents need no reset because occupancy gates every read
    always_ff @(posedge clock) begin
        if (push_fire) begin
            mem[wr_ptr_q] <= {push_chip, push_reg, push_data};
        end
    end

    // FIFO pointers; reset drops every queued entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FSM, holding registers and registered bus outputs; reset aborts without restoring select
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            chip_q      <= 1'b0;
            reg_q       <= 4'h0;
            data_q      <= 8'h00;
            saved_sel_q <= 1'b0;
            skip_q      <= 1'b0;
            own_q       <= 1'b0;
            bdir_q      <= 1'b0;
            bc1_q       <= 1'b0;
            dout_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chip_q      <= chip_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            saved_sel_q <= saved_sel_d;
            skip_q      <= skip_d;
            own_q       <= own_d;
            bdir_q      <= bdir_d;
            bc1_q       <= bc1_d;
            dout_q      <= dout_d;
        end
    end

endmodule

// File: tb/tb_psg_write_sequencer.sv
// Bench for psg_write_sequencer: directed and random writes checked against a cycle trace model.
// Each queued entry expands to a list of expected bus cycles built from the phase rules.
// Honours PSGSEQ_SKIP_SELECT_EN when the build defines it.
module tb_psg_write_sequencer;

    localparam int DEPTH = 16;
    localparam int HOLD  = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       push_valid = 1'b0;
    logic       push_ready;
    logic       push_chip = 1'b0;
    logic [3:0] push_reg = 4'h0;
    logic [7:0] push_data = 8'h00;
    logic       cpu_busy = 1'b0;
    logic       cur_sel = 1'b0;
    logic       own;
    logic       bus_bdir;
    logic       bus_bc1;
    logic [7:0] bus_d;
    logic       cpu_wait;
    logic [4:0] level;

    psg_write_sequencer #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_chip  (push_chip),
        .push_reg   (push_reg),
        .push_data  (push_data),
        .cpu_busy   (cpu_busy),
        .cur_sel    (cur_sel),
        .own        (own),
        .bus_bdir   (bus_bdir),
        .bus_bc1    (bus_bc1),
        .bus_d      (bus_d),
        .cpu_wait   (cpu_wait),
        .level      (level)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: pending FIFO entries and the expected per-cycle bus trace {own,bdir,bc1,d}
    logic [12:0] fq[$];
    logic [10:0] trace[$];
    logic [10:0] cur = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void add_phase(input logic bc1, input logic [7:0] d);
        for (int i = 0; i < HOLD; i++) trace.push_back({1'b1, 1'b1, bc1, d});
        trace.push_back({1'b1, 1'b0, 1'b0, d});
    endfunction

    function automatic void build(input logic [12:0] e, input logic sel);
        logic skip;
`ifdef PSGSEQ_SKIP_SELECT_EN
        skip = (e[12] == sel);
`else
        skip = 1'b0;
`endif
        if (!skip) add_phase(1'b1, {7'h7F, ~e[12]});
        add_phase(1'b1, {4'h0, e[11:8]});
        add_phase(1'b0, e[7:0]);
        if (!skip) add_phase(1'b1, {7'h7F, ~sel});
        trace.push_back(11'h000);   // one idle clock before the next entry may start
    endfunction

    // One clock: predict pops/pushes from pre-edge inputs, then compare every output
    task automatic step();
        logic        start;
        logic        acc;
        logic        sel_s;
        logic [12:0] ent;
        start = (trace.size() == 0) && (fq.size() != 0) && !cpu_busy;
        acc   = push_valid && (fq.size() != DEPTH);
        sel_s = cur_sel;
        ent   = {push_chip, push_reg, push_data};
        @(posedge clock);
        if (start) build(fq.pop_front(), sel_s);
        if (acc) fq.push_back(ent);
        #1;
        cur = (trace.size() != 0) ? trace.pop_front() : 11'h000;
        chk("own", own, cur[10]);
        chk("bdir", bus_bdir, cur[9]);
        chk("bc1", bus_bc1, cur[8]);
        chk("bus_d", bus_d, cur[7:0]);
        chk("cpu_wait", cpu_wait, cpu_busy & cur[10]);
        chk("level", level, fq.size());
        chk("push_ready", push_ready, fq.size() != DEPTH);
    endtask

    task automatic push_one(input logic c, input logic [3:0] r, input logic [7:0] d);
        push_valid = 1'b1;
        push_chip  = c;
        push_reg   = r;
        push_data  = d;
        step();
        push_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 600 && (fq.size() != 0 || trace.size() != 0); n++) step();
        chk("drained_level", level, 0);
    endtask

    initial begin
        int oc;
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_own", own, 0);
        chk("rst_bdir", bus_bdir, 0);
        chk("rst_bc1", bus_bc1, 0);
        chk("rst_bus_d", bus_d, 0);
        chk("rst_wait", cpu_wait, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", push_ready, 1);
        reset = 1'b0;

        // Directed single write: chip 1, reg 7, 0x38 with chip 0 selected
        cur_sel = 1'b0;
        push_one(1'b1, 4'h7, 8'h38);
        oc = 0;
        for (int n = 0; n < 14; n++) begin
            step();
            if (own) oc++;
        end
        chk("seq_len", oc, 4 * (HOLD + 1));

        // Fill past capacity while the CPU holds the bus, then replay in order
        cpu_busy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++)
            push_one(1'($urandom), 4'($urandom), 8'($urandom));
        chk("full_level", level, DEPTH);
        chk("full_ready", push_ready, 0);
        cpu_busy = 1'b0;
        drain();

        // CPU cycle arriving on the third owned clock is stalled until own drops
        cur_sel = 1'b1;
        push_one(1'b0, 4'hA, 8'hC3);
        oc = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (own) oc++;
            if (oc == 3 && own && !cpu_busy) begin
                cpu_busy = 1'b1;
                #1;
                chk("wait_rise", cpu_wait, 1);
            end
            if (oc > 0 && !own) break;
        end
        chk("wait_fall", cpu_wait, 0);
        chk("wait_seq_len", oc, 4 * (HOLD + 1));
        cpu_busy = 1'b0;
        drain();

        // Reset during the data strobe aborts and flushes the queue
        cpu_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_one(1'b1, 4'(i), 8'(8'h10 + i));
        cpu_busy = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (cur[9] && !cur[8]) break;
        end
        chk("in_data_strobe", {bus_bdir, bus_bc1}, 2'b10);
        reset = 1'b1;
        #1;
        chk("arst_own", own, 0);
        chk("arst_bdir", bus_bdir, 0);
        chk("arst_bc1", bus_bc1, 0);
        chk("arst_bus_d", bus_d, 0);
        chk("arst_level", level, 0);
        chk("arst_ready", push_ready, 1);
        fq.delete();
        trace.delete();
        #1;
        reset = 1'b0;
        for (int n = 0; n < 3; n++) step();

`ifdef PSGSEQ_SKIP_SELECT_EN
        // Entry for the already-selected chip runs only address and data phases
        cur_sel = 1'b1;
        push_one(1'b1, 4'h0, 8'h55);
        oc = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (own) oc++;
        end
        chk("skip_len", oc, 2 * (HOLD + 1));
`endif

        // Push and pop on the same clock at level 3
        cpu_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_one(1'b0, 4'(i + 4), 8'(8'hA0 + i));
        chk("pp_pre_level", level, 3);
        cpu_busy = 1'b0;
        push_one(1'b1, 4'hF, 8'h5A);
        chk("pp_level", level, 3);
        drain();

        // Random traffic with CPU contention and select changes
        for (int n = 0; n < 500; n++) begin
            push_valid = ($urandom_range(0, 2) == 0);
            push_chip  = 1'($urandom);
            push_reg   = 4'($urandom);
            push_data  = 8'($urandom);
            cpu_busy   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) cur_sel = ~cur_sel;
            step();
        end
        push_valid = 1'b0;
        cpu_busy   = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
